// File: rtl/si570_freq_seq_pkg.sv
// Shared types and constants for the Si570 frequency-reprogramming sequencer.
// Holds the register map, the command payload struct and the divider/RFREQ byte packer.
package si570_pkg;

    localparam int unsigned HS_DIV_W = 3;
    localparam int unsigned N1_W     = 7;
    localparam int unsigned RFREQ_W  = 38;
    localparam int unsigned SADDR_W  = 7;
    localparam int unsigned BYTE_W   = 8;
    localparam int unsigned NBYTES   = 4;
    localparam int unsigned BURST_W  = 2;

    localparam logic [7:0] REG_HI       = 8'd7;
    localparam logic [7:0] REG_LO       = 8'd11;
    localparam logic [7:0] REG_NEWFREQ  = 8'd135;
    localparam logic [7:0] REG_FREEZE   = 8'd137;
    localparam logic [7:0] FREEZE_DCO   = 8'h10;
    localparam logic [7:0] UNFREEZE_DCO = 8'h00;
    localparam logic [7:0] NEW_FREQ     = 8'h40;
    localparam int unsigned NEW_FREQ_BIT = 6;

    typedef enum logic [3:0] {
        S_IDLE,
        S_MUX,
        S_FREEZE,
        S_WR_HI,
        S_WR_LO,
        S_UNFREEZE,
        S_NEWFREQ,
        S_POLL_REQ,
        S_POLL_RSP,
        S_SETTLE,
        S_DONE
    } state_t;

    typedef struct packed {
        logic [SADDR_W-1:0]             slave_address;
        logic [BYTE_W-1:0]              reg_address;
        logic [NBYTES-1:0][BYTE_W-1:0]  wdata;
        logic [BURST_W-1:0]             burst_count;
        logic                           rd_wrn;
    } rv0_cmd_t;

    // Si570 registers 7..12 in transmit order: index 0 is reg 7.
    function automatic logic [5:0][BYTE_W-1:0] pack_regs(
        input logic [HS_DIV_W-1:0] hs_div,
        input logic [N1_W-1:0]     n1,
        input logic [RFREQ_W-1:0]  rfreq
    );
        logic [5:0][BYTE_W-1:0] b;
        b[0] = {hs_div, n1[6:2]};
        b[1] = {n1[1:0], rfreq[37:32]};
        b[2] = rfreq[31:24];
        b[3] = rfreq[23:16];
        b[4] = rfreq[15:8];
        b[5] = rfreq[7:0];
        return b;
    endfunction

endpackage

// File: rtl/si570_freq_seq_if.sv
// Command (rv0) and read-response (rv1) channels between the sequencer and i2c_master.
interface si570_freq_seq_if;
    import si570_pkg::*;

    logic                           rv0_valid;
    logic                           rv0_ready;
    logic [SADDR_W-1:0]             rv0_slave_address;
    logic [BYTE_W-1:0]              rv0_reg_address;
    logic [NBYTES-1:0][BYTE_W-1:0]  rv0_wdata;
    logic [BURST_W-1:0]             rv0_burst_count;
    logic                           rv0_rd_wrn;

    logic                           rv1_valid;
    logic                           rv1_ready;
    logic [NBYTES-1:0][BYTE_W-1:0]  rv1_rdata;

    modport master (
        output rv0_valid, rv0_slave_address, rv0_reg_address, rv0_wdata,
               rv0_burst_count, rv0_rd_wrn, rv1_ready,
        input  rv0_ready, rv1_valid, rv1_rdata
    );

    modport slave (
        input  rv0_valid, rv0_slave_address, rv0_reg_address, rv0_wdata,
               rv0_burst_count, rv0_rd_wrn, rv1_ready,
        output rv0_ready, rv1_valid, rv1_rdata
    );

endinterface

// File: rtl/si570_freq_seq.sv
// Reprograms the Si570 through the I2C switch: freeze DCO, write HS_DIV/N1/RFREQ,
// unfreeze, assert NewFreq, poll until it self-clears, then wait for the output to settle.
module si570_freq_seq
    import si570_pkg::*;
#(
    parameter logic [6:0]  MuxAddr      = 7'h74,
    parameter logic [7:0]  MuxChannel   = 8'h80,
    parameter logic [6:0]  DevAddr      = 7'h5D,
    parameter int unsigned SettleCycles = 100000,
    parameter int unsigned PollLimit    = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_start,
    input  logic [HS_DIV_W-1:0]  i_hs_div,
    input  logic [N1_W-1:0]      i_n1,
    input  logic [RFREQ_W-1:0]   i_rfreq,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_error,
    si570_freq_seq_if.master     io_bus
);

    localparam int unsigned CNT_W_RAW  = $clog2(SettleCycles + 1);
    localparam int unsigned CNT_W      = (CNT_W_RAW > 0) ? CNT_W_RAW : 1;
    localparam int unsigned POLL_W_RAW = $clog2(PollLimit + 1);
    localparam int unsigned POLL_W     = (POLL_W_RAW > 0) ? POLL_W_RAW : 1;

    state_t                  r_state;
    rv0_cmd_t                r_cmd;
    logic                    r_valid;
    logic                    r_rv1_ready;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_error;
    logic [HS_DIV_W-1:0]     r_hs_div;
    logic [N1_W-1:0]         r_n1;
    logic [RFREQ_W-1:0]      r_rfreq;
    logic [POLL_W-1:0]       r_poll_cnt;
    logic [CNT_W-1:0]        r_settle_cnt;

    logic [5:0][BYTE_W-1:0]  w_regs;
    rv0_cmd_t                w_cmd;
    state_t                  w_next_cmd;
    logic                    w_busy_bit;
    logic                    w_unused;

    assign w_regs     = pack_regs(r_hs_div, r_n1, r_rfreq);
    assign w_busy_bit = io_bus.rv1_rdata[0][NEW_FREQ_BIT];
    assign w_unused   = ^{io_bus.rv1_rdata[3:1], io_bus.rv1_rdata[0][7],
                          io_bus.rv1_rdata[0][5:0]};

    // Payload and successor for the command owned by the current state; IDLE prepares MUX.
    always_comb begin
        w_cmd               = '0;
        w_next_cmd          = S_IDLE;
        w_cmd.slave_address = DevAddr;
        case (r_state)
            S_IDLE, S_MUX: begin
                w_cmd.slave_address = MuxAddr;
                w_cmd.reg_address   = MuxChannel;
                w_cmd.wdata[0]      = MuxChannel;
                w_next_cmd          = S_FREEZE;
            end
            S_FREEZE: begin
                w_cmd.reg_address = REG_FREEZE;
                w_cmd.wdata[0]    = FREEZE_DCO;
                w_next_cmd        = S_WR_HI;
            end
            S_WR_HI: begin
                w_cmd.reg_address = REG_HI;
                w_cmd.wdata[0]    = w_regs[0];
                w_cmd.wdata[1]    = w_regs[1];
                w_cmd.wdata[2]    = w_regs[2];
                w_cmd.wdata[3]    = w_regs[3];
                w_cmd.burst_count = 2'd3;
                w_next_cmd        = S_WR_LO;
            end
            S_WR_LO: begin
                w_cmd.reg_address = REG_LO;
                w_cmd.wdata[0]    = w_regs[4];
                w_cmd.wdata[1]    = w_regs[5];
                w_cmd.burst_count = 2'd1;
                w_next_cmd        = S_UNFREEZE;
            end
            S_UNFREEZE: begin
                w_cmd.reg_address = REG_FREEZE;
                w_cmd.wdata[0]    = UNFREEZE_DCO;
                w_next_cmd        = S_NEWFREQ;
            end
            S_NEWFREQ: begin
                w_cmd.reg_address = REG_NEWFREQ;
                w_cmd.wdata[0]    = NEW_FREQ;
                w_next_cmd        = S_POLL_REQ;
            end
            S_POLL_REQ: begin
                w_cmd.reg_address = REG_NEWFREQ;
                w_cmd.rd_wrn      = 1'b1;
                w_next_cmd        = S_POLL_RSP;
            end
            default: begin
                w_cmd = '0;
            end
        endcase
    end

    // Sequencer state and all registered outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_cmd        <= '0;
            r_valid      <= 1'b0;
            r_rv1_ready  <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_hs_div     <= '0;
            r_n1         <= '0;
            r_rfreq      <= '0;
            r_poll_cnt   <= '0;
            r_settle_cnt <= '0;
        end else begin
            r_done  <= 1'b0;
            r_error <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_hs_div   <= i_hs_div;
                        r_n1       <= i_n1;
                        r_rfreq    <= i_rfreq;
                        r_poll_cnt <= '0;
                        r_busy     <= 1'b1;
                        r_cmd      <= w_cmd;
                        r_valid    <= 1'b1;
                        r_state    <= S_MUX;
                    end
                end
                S_MUX, S_FREEZE, S_WR_HI, S_WR_LO, S_UNFREEZE, S_NEWFREQ, S_POLL_REQ: begin
                    // Valid drops for a cycle after each handshake while the next payload loads.
                    if (!r_valid) begin
                        r_cmd   <= w_cmd;
                        r_valid <= 1'b1;
                    end else if (io_bus.rv0_ready) begin
                        r_valid <= 1'b0;
                        r_state <= w_next_cmd;
                        if (r_state == S_POLL_REQ) begin
                            r_rv1_ready <= 1'b1;
                        end
                    end
                end
                S_POLL_RSP: begin
                    if (io_bus.rv1_valid) begin
                        r_rv1_ready <= 1'b0;
                        if (!w_busy_bit) begin
                            r_settle_cnt <= CNT_W'(SettleCycles - 1);
                            r_state      <= S_SETTLE;
                        end else if (r_poll_cnt < POLL_W'(PollLimit)) begin
                            r_poll_cnt <= r_poll_cnt + POLL_W'(1);
                            r_state    <= S_POLL_REQ;
                        end else begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_error <= 1'b1;
                            r_cmd   <= '0;
                            r_state <= S_DONE;
                        end
                    end
                end
                S_SETTLE: begin
                    if (r_settle_cnt == '0) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_cmd   <= '0;
                        r_state <= S_DONE;
                    end else begin
                        r_settle_cnt <= r_settle_cnt - CNT_W'(1);
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_busy                   = r_busy;
    assign o_done                   = r_done;
    assign o_error                  = r_error;
    assign io_bus.rv0_valid         = r_valid;
    assign io_bus.rv0_slave_address = r_cmd.slave_address;
    assign io_bus.rv0_reg_address   = r_cmd.reg_address;
    assign io_bus.rv0_wdata         = r_cmd.wdata;
    assign io_bus.rv0_burst_count   = r_cmd.burst_count;
    assign io_bus.rv0_rd_wrn        = r_cmd.rd_wrn;
    assign io_bus.rv1_ready         = r_rv1_ready;

endmodule

// File: tb/tb_si570_freq_seq.sv
// Bench for si570_freq_seq: an i2c_master stand-in logs every command and serves poll
// responses; each scenario is compared against a byte-level model of the register program.
module tb_si570_freq_seq;
    import si570_pkg::*;

    localparam int unsigned SETTLE    = 20;
    localparam int unsigned PLIM      = 4;
    localparam int          CYC_LIMIT = 2000;
    localparam logic [6:0]  MUX_A     = 7'h74;
    localparam logic [7:0]  MUX_CH    = 8'h80;
    localparam logic [6:0]  DEV_A     = 7'h5D;

    typedef struct packed {
        logic [6:0]  sa;
        logic [7:0]  ra;
        logic [31:0] wd;
        logic [1:0]  bc;
        logic        rw;
    } cmd_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  hs = '0;
    logic [6:0]  n1 = '0;
    logic [37:0] rf = '0;
    logic        busy, done, err;

    si570_freq_seq_if bus ();

    si570_freq_seq #(.SettleCycles(SETTLE), .PollLimit(PLIM)) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_start  (start),
        .i_hs_div (hs),
        .i_n1     (n1),
        .i_rfreq  (rf),
        .o_busy   (busy),
        .o_done   (done),
        .o_error  (err),
        .io_bus   (bus)
    );

    initial forever #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_fail = 0;
    int          cyc = 0;
    cmd_t        cmd_log[$];
    int          rsp_cyc[$];
    int          done_cyc[$];
    logic        done_err[$];
    logic [7:0]  rsp_q[$];
    cmd_t        exp_q[$];
    int          rdy_delay = 0;
    bit          early_ready = 1'b0;
    bit          spurious = 1'b0;
    int          busy_in_done = 0;
    int          stray_err = 0;

    function automatic cmd_t mk(input logic [6:0] sa, input logic [7:0] ra,
                                input logic [31:0] wd, input logic [1:0] bc, input logic rw);
        cmd_t c;
        c.sa = sa; c.ra = ra; c.wd = wd; c.bc = bc; c.rw = rw;
        return c;
    endfunction

    function automatic cmd_t cur_cmd();
        return mk(bus.rv0_slave_address, bus.rv0_reg_address, bus.rv0_wdata,
                  bus.rv0_burst_count, bus.rv0_rd_wrn);
    endfunction

    // i2c_master stand-in: ready with programmable delay, response server, event logger.
    initial begin : bfm
        int          vcnt;
        bit          pending;
        cmd_t        prev;
        logic [31:0] tmp;
        vcnt = 0;
        pending = 1'b0;
        prev = '0;
        bus.rv0_ready = 1'b0;
        bus.rv1_valid = 1'b0;
        bus.rv1_rdata = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (bus.rv0_valid) begin
                vcnt++;
                if (pending) begin
                    n_cmp++;
                    if (cur_cmd() !== prev) begin
                        n_fail++;
                        $display("FAIL payload_stable cyc %0d: got %h required %h", cyc, cur_cmd(), prev);
                    end
                end
                bus.rv0_ready = (vcnt > rdy_delay);
                if (bus.rv0_ready) begin
                    cmd_log.push_back(cur_cmd());
                    pending = 1'b0;
                end else begin
                    prev = cur_cmd();
                    pending = 1'b1;
                end
            end else begin
                vcnt = 0;
                pending = 1'b0;
                bus.rv0_ready = early_ready & 1'($urandom_range(0, 1));
            end
            if (bus.rv1_ready) begin
                tmp = $urandom;
                tmp[7:0] = (rsp_q.size() > 0) ? rsp_q.pop_front() : 8'h00;
                bus.rv1_valid = 1'b1;
                bus.rv1_rdata = tmp;
                rsp_cyc.push_back(cyc);
            end else begin
                bus.rv1_valid = spurious & 1'($urandom_range(0, 1));
                bus.rv1_rdata = 32'($urandom) | 32'h40;
            end
            if (done) begin
                done_cyc.push_back(cyc);
                done_err.push_back(err);
                if (busy) busy_in_done++;
            end
            if (err && !done) stray_err++;
        end
    end

    // Reference register program: six writes, then one read of reg 135 per poll.
    task automatic model(input logic [2:0] h, input logic [6:0] n, input logic [37:0] r,
                         input int reads);
        logic [47:0] word;
        logic [7:0]  b [6];
        word = {h, n, r};
        for (int k = 0; k < 6; k++) b[k] = word[47 - 8*k -: 8];
        exp_q.delete();
        exp_q.push_back(mk(MUX_A, MUX_CH, {24'h0, MUX_CH}, 2'd0, 1'b0));
        exp_q.push_back(mk(DEV_A, 8'd137, 32'h10, 2'd0, 1'b0));
        exp_q.push_back(mk(DEV_A, 8'd7, {b[3], b[2], b[1], b[0]}, 2'd3, 1'b0));
        exp_q.push_back(mk(DEV_A, 8'd11, {16'h0, b[5], b[4]}, 2'd1, 1'b0));
        exp_q.push_back(mk(DEV_A, 8'd137, 32'h00, 2'd0, 1'b0));
        exp_q.push_back(mk(DEV_A, 8'd135, 32'h40, 2'd0, 1'b0));
        repeat (reads) exp_q.push_back(mk(DEV_A, 8'd135, 32'h0, 2'd0, 1'b1));
    endtask

    task automatic run_seq(input string name, input logic [2:0] h, input logic [6:0] n,
                           input logic [37:0] r, input logic [7:0] rsps[$], input bit glitch);
        int reads;
        bit exp_err;
        int t0;
        int gap;
        int exp_gap;
        bit glitched;
        int ncmp_cmds;
        reads = 0;
        exp_err = 1'b1;
        glitched = 1'b0;
        for (int k = 0; k <= int'(PLIM); k++) begin
            reads++;
            if (!((k < rsps.size()) ? rsps[k][6] : 1'b0)) begin
                exp_err = 1'b0;
                break;
            end
        end
        model(h, n, r, reads);
        cmd_log.delete(); rsp_cyc.delete(); done_cyc.delete(); done_err.delete();
        rsp_q = rsps;
        busy_in_done = 0;
        stray_err = 0;

        @(negedge clk);
        hs = h; n1 = n; rf = r; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_cmp++;
        if (busy !== 1'b1 || bus.rv0_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL %s start_latency: busy=%b valid=%b required 1/1", name, busy, bus.rv0_valid);
        end

        t0 = cyc;
        while (done_cyc.size() == 0 && (cyc - t0) < CYC_LIMIT) begin
            @(negedge clk);
            if (glitch && !glitched && cmd_log.size() == 2) begin
                hs = ~h; n1 = ~n; rf = ~r; start = 1'b1;
                glitched = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        n_cmp++;
        if (done_cyc.size() == 0) begin
            n_fail++;
            $display("FAIL %s timeout: no done within %0d cycles", name, CYC_LIMIT);
        end
        repeat (SETTLE + 10) @(negedge clk);

        n_cmp++;
        if (cmd_log.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL %s cmd_count: got %0d required %0d", name, cmd_log.size(), exp_q.size());
        end
        ncmp_cmds = (cmd_log.size() < exp_q.size()) ? cmd_log.size() : exp_q.size();
        for (int k = 0; k < ncmp_cmds; k++) begin
            n_cmp++;
            if (cmd_log[k] !== exp_q[k]) begin
                n_fail++;
                $display("FAIL %s cmd[%0d]: got %h required %h", name, k, cmd_log[k], exp_q[k]);
            end
        end
        n_cmp++;
        if (rsp_cyc.size() != reads) begin
            n_fail++;
            $display("FAIL %s poll_reads: got %0d required %0d", name, rsp_cyc.size(), reads);
        end
        n_cmp++;
        if (done_cyc.size() != 1) begin
            n_fail++;
            $display("FAIL %s done_pulses: got %0d required 1", name, done_cyc.size());
        end
        if (done_cyc.size() > 0) begin
            n_cmp++;
            if (done_err[0] !== exp_err) begin
                n_fail++;
                $display("FAIL %s error_flag: got %b required %b", name, done_err[0], exp_err);
            end
            if (rsp_cyc.size() > 0) begin
                gap = done_cyc[0] - rsp_cyc[rsp_cyc.size() - 1] - 1;
                exp_gap = exp_err ? 0 : int'(SETTLE);
                n_cmp++;
                if (gap != exp_gap) begin
                    n_fail++;
                    $display("FAIL %s settle_gap: got %0d required %0d", name, gap, exp_gap);
                end
            end
        end
        n_cmp++;
        if (busy_in_done != 0 || stray_err != 0) begin
            n_fail++;
            $display("FAIL %s done_flags: busy_in_done=%0d stray_err=%0d required 0/0", name, busy_in_done, stray_err);
        end
        n_cmp++;
        if ({busy, bus.rv0_valid, bus.rv1_ready, bus.rv0_slave_address, bus.rv0_reg_address,
             bus.rv0_wdata, bus.rv0_burst_count, bus.rv0_rd_wrn} !== '0) begin
            n_fail++;
            $display("FAIL %s idle_outputs: busy=%b valid=%b payload=%h required all 0", name, busy,
                     bus.rv0_valid, cur_cmd());
        end
    endtask

    task automatic check_all_zero(input string name);
        n_cmp++;
        if ({busy, done, err, bus.rv0_valid, bus.rv1_ready, bus.rv0_slave_address,
             bus.rv0_reg_address, bus.rv0_wdata, bus.rv0_burst_count, bus.rv0_rd_wrn} !== '0) begin
            n_fail++;
            $display("FAIL %s: busy=%b done=%b err=%b valid=%b rv1_ready=%b payload=%h required all 0",
                     name, busy, done, err, bus.rv0_valid, bus.rv1_ready, cur_cmd());
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b1;
        repeat (3) @(negedge clk);
        check_all_zero("reset_state");
        start = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_all_zero("post_reset_idle");
    endtask

    task automatic test_full_sequence();
        logic [7:0] q[$];
        q = {8'h00};
        rdy_delay = 0;
        run_seq("full", 3'b001, 7'h07, 38'h2_BC01_1E2A, q, 1'b0);
        n_cmp++;
        if (cmd_log.size() < 4 || cmd_log[2].wd !== 32'h01BC_C221 || cmd_log[3].wd !== 32'h0000_2A1E) begin
            n_fail++;
            $display("FAIL full_bytes: hi=%h lo=%h required 01bcc221 00002a1e",
                     (cmd_log.size() > 2) ? cmd_log[2].wd : 32'h0,
                     (cmd_log.size() > 3) ? cmd_log[3].wd : 32'h0);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] q[$];
        q = {8'h00};
        rdy_delay = 5;
        run_seq("backpressure", 3'b001, 7'h07, 38'h2_BC01_1E2A, q, 1'b0);
        rdy_delay = 0;
    endtask

    task automatic test_poll_retry();
        logic [7:0] q[$];
        q = {8'h40, 8'h40, 8'h00};
        run_seq("poll_retry", 3'b101, 7'h2A, 38'h1_2345_6789, q, 1'b0);
    endtask

    task automatic test_poll_exhaust();
        logic [7:0] q[$];
        q = {8'h40, 8'h40, 8'h40, 8'h40, 8'h40, 8'h40, 8'h40};
        run_seq("poll_exhaust", 3'b011, 7'h11, 38'h3_0F0F_F0F0, q, 1'b0);
    endtask

    task automatic test_start_while_busy();
        logic [7:0] q[$];
        q = {8'h00};
        run_seq("start_busy", 3'b110, 7'h55, 38'h0_A5A5_5A5A, q, 1'b1);
    endtask

    task automatic test_random();
        logic [7:0] q[$];
        int len;
        early_ready = 1'b1;
        spurious = 1'b1;
        for (int it = 0; it < 6; it++) begin
            q.delete();
            len = $urandom_range(0, 6);
            for (int k = 0; k < len; k++) q.push_back(8'($urandom));
            rdy_delay = $urandom_range(0, 3);
            run_seq($sformatf("random%0d", it), 3'($urandom), 7'($urandom),
                    {6'($urandom), 32'($urandom)}, q, 1'b0);
        end
        early_ready = 1'b0;
        spurious = 1'b0;
        rdy_delay = 0;
    endtask

    task automatic test_reset_mid();
        logic [7:0] q[$];
        int t0;
        rsp_q = {8'h40, 8'h40, 8'h40, 8'h40, 8'h40, 8'h40};
        @(negedge clk);
        hs = 3'b010; n1 = 7'h33; rf = 38'h1_1111_2222; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t0 = cyc;
        while (!bus.rv1_ready && (cyc - t0) < CYC_LIMIT) @(negedge clk);
        n_cmp++;
        if (!bus.rv1_ready) begin
            n_fail++;
            $display("FAIL reset_mid_reach: rv1_ready=%b required 1", bus.rv1_ready);
        end
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("reset_mid_async");
        @(negedge clk);
        rsp_q.delete();
        rst_n = 1'b1;
        q = {8'h00};
        run_seq("after_reset", 3'b001, 7'h07, 38'h2_BC01_1E2A, q, 1'b0);
    endtask

    initial begin
        test_reset();
        test_full_sequence();
        test_backpressure();
        test_poll_retry();
        test_poll_exhaust();
        test_start_while_busy();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
